// File: rtl/risc32_mem_bus_if_pkg.sv
// Shared constants for the RISC32 memory stage: widths, ALU op codes, FSM states.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package risc32_mem_bus_if_pkg;

  localparam int REG_BUS    = 32;
  localparam int ALU_OP_BUS = 8;
  localparam int STALL_BUS  = 6;

  localparam logic NO_STOP = 1'b0;
  localparam logic STOP    = 1'b1;

  localparam logic [ALU_OP_BUS-1:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [ALU_OP_BUS-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [ALU_OP_BUS-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [ALU_OP_BUS-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [ALU_OP_BUS-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [ALU_OP_BUS-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [ALU_OP_BUS-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [ALU_OP_BUS-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [ALU_OP_BUS-1:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  function automatic logic is_load(input logic [ALU_OP_BUS-1:0] op);
    return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
           (op == EXE_LHU_OP) || (op == EXE_LW_OP);
  endfunction

  function automatic logic is_store(input logic [ALU_OP_BUS-1:0] op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

  function automatic logic is_mem_op(input logic [ALU_OP_BUS-1:0] op);
    return is_load(op) || is_store(op);
  endfunction

  function automatic logic is_half(input logic [ALU_OP_BUS-1:0] op);
    return (op == EXE_LH_OP) || (op == EXE_LHU_OP) || (op == EXE_SH_OP);
  endfunction

  function automatic logic is_word(input logic [ALU_OP_BUS-1:0] op);
    return (op == EXE_LW_OP) || (op == EXE_SW_OP);
  endfunction

  // Halfwords need an even address, words need a word-aligned address.
  function automatic logic is_misaligned(input logic [ALU_OP_BUS-1:0] op, input logic [1:0] a);
    return (is_half(op) && a[0]) || (is_word(op) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/risc32_mem_bus_if_if.sv
// Data-bus bundle between the MEM-stage master and the memory slave.
// Latency: n/a (wires only).
// Backpressure: slave holds off the master by delaying the one-cycle bus_ack pulse.
interface risc32_dbus_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/risc32_mem_bus_if_lane.sv
// Big-endian byte-lane logic: select generation, store replication, load extract/extend.
// Latency: purely combinational.
// Backpressure: none.
module risc32_mem_lane
  import risc32_mem_bus_if_pkg::*;
(
  input  logic [ALU_OP_BUS-1:0] alu_op_i,
  input  logic [1:0]            a_i,
  input  logic [REG_BUS-1:0]    reg2_i,
  input  logic [REG_BUS-1:0]    rdata_i,
  output logic [3:0]            sel_o,
  output logic [REG_BUS-1:0]    wdata_o,
  output logic [REG_BUS-1:0]    ldata_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Pick the addressed byte/half from the bus word; byte 0 sits in the MSBs.
  always_comb begin
    byte_v = rdata_i[31:24];
    case (a_i)
      2'd0:    byte_v = rdata_i[31:24];
      2'd1:    byte_v = rdata_i[23:16];
      2'd2:    byte_v = rdata_i[15:8];
      default: byte_v = rdata_i[7:0];
    endcase
    half_v = a_i[1] ? rdata_i[15:0] : rdata_i[31:16];
  end

  // Lane select, replicated store data and extended load data per op.
  always_comb begin
    sel_o   = 4'b0000;
    wdata_o = '0;
    ldata_o = '0;
    case (alu_op_i)
      EXE_LB_OP:  begin sel_o = 4'b1000 >> a_i; ldata_o = {{24{byte_v[7]}}, byte_v}; end
      EXE_LBU_OP: begin sel_o = 4'b1000 >> a_i; ldata_o = {24'h0, byte_v}; end
      EXE_LH_OP:  begin sel_o = a_i[1] ? 4'b0011 : 4'b1100; ldata_o = {{16{half_v[15]}}, half_v}; end
      EXE_LHU_OP: begin sel_o = a_i[1] ? 4'b0011 : 4'b1100; ldata_o = {16'h0, half_v}; end
      EXE_LW_OP:  begin sel_o = 4'b1111; ldata_o = rdata_i; end
      EXE_SB_OP:  begin sel_o = 4'b1000 >> a_i; wdata_o = {4{reg2_i[7:0]}}; end
      EXE_SH_OP:  begin sel_o = a_i[1] ? 4'b0011 : 4'b1100; wdata_o = {2{reg2_i[15:0]}}; end
      EXE_SW_OP:  begin sel_o = 4'b1111; wdata_o = reg2_i; end
      default:    ;
    endcase
  end

endmodule

// File: rtl/risc32_mem_bus_if.sv
// MEM-stage data-bus master: one req/ack transaction per load/store, stall request while busy.
// Latency: req one cycle after the op appears; load data valid the cycle after ack.
// Backpressure: waits indefinitely for bus_ack; holds load data in DONE while stall[4] is set.
// Optional misaligned-access trap: RISC32_MEM_ALIGN_CHECK_EN (adds addr_err_o).
module risc32_mem_bus_if
  import risc32_mem_bus_if_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_BUS-1:0]  stall_i,
  input  logic                  flush_i,
  input  logic [ALU_OP_BUS-1:0] alu_op_i,
  input  logic [REG_BUS-1:0]    mem_addr_i,
  input  logic [REG_BUS-1:0]    reg2_i,
  risc32_dbus_if.master         bus,
  output logic [REG_BUS-1:0]    load_data_o,
  output logic                  stallreq_o
`ifdef RISC32_MEM_ALIGN_CHECK_EN
  ,
  output logic [1:0]            addr_err_o
`endif
);

  mem_state_e            state_q, state_d;
  logic                  req_q, req_d, we_q, we_d, flushed_q, flushed_d;
  logic [REG_BUS-1:0]    addr_q, addr_d, wdata_q, wdata_d, load_data_q, load_data_d;
  logic [3:0]            sel_q, sel_d;
  logic [ALU_OP_BUS-1:0] op_q, op_d;
  logic [1:0]            a_q, a_d;

  logic                  misal, launch_ok;
  logic [ALU_OP_BUS-1:0] lane_op;
  logic [1:0]            lane_a;
  logic [3:0]            lane_sel;
  logic [REG_BUS-1:0]    lane_wdata, lane_ldata;
  logic                  unused_stall;

  assign unused_stall = ^{stall_i[5], stall_i[2:0]};

`ifdef RISC32_MEM_ALIGN_CHECK_EN
  logic [1:0] addr_err_q, addr_err_d;
  assign misal = is_misaligned(alu_op_i, mem_addr_i[1:0]);
  assign addr_err_d = (state_q == MEM_IDLE && is_mem_op(alu_op_i) && !flush_i && misal &&
                       stall_i[3] == NO_STOP) ? {is_load(alu_op_i), is_store(alu_op_i)} : 2'b00;
  assign addr_err_o = addr_err_q;

  // One-cycle error pulse for a trapped access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) addr_err_q <= 2'b00;
    else     addr_err_q <= addr_err_d;
  end
`else
  assign misal = 1'b0;
`endif

  assign launch_ok = is_mem_op(alu_op_i) && !flush_i && !misal;

  // In IDLE the lane logic sees the live EX/MEM op; afterwards the captured one.
  assign lane_op = (state_q == MEM_IDLE) ? alu_op_i : op_q;
  assign lane_a  = (state_q == MEM_IDLE) ? mem_addr_i[1:0] : a_q;

  risc32_mem_lane u_lane (
    .alu_op_i (lane_op),
    .a_i      (lane_a),
    .reg2_i   (reg2_i),
    .rdata_i  (bus.bus_rdata),
    .sel_o    (lane_sel),
    .wdata_o  (lane_wdata),
    .ldata_o  (lane_ldata)
  );

  // Next-state, registered bus outputs and stall request.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    sel_d       = sel_q;
    wdata_d     = wdata_q;
    op_d        = op_q;
    a_d         = a_q;
    flushed_d   = flushed_q;
    load_data_d = load_data_q;
    stallreq_o  = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        stallreq_o = launch_ok;
        if (launch_ok && stall_i[3] == NO_STOP) begin
          req_d     = 1'b1;
          we_d      = is_store(alu_op_i);
          addr_d    = {mem_addr_i[31:2], 2'b00};
          sel_d     = lane_sel;
          wdata_d   = lane_wdata;
          op_d      = alu_op_i;
          a_d       = mem_addr_i[1:0];
          flushed_d = 1'b0;
          state_d   = MEM_REQ;
        end
      end
      MEM_REQ: begin
        stallreq_o = 1'b1;
        // A flush cannot abort the bus cycle; remember it and drop the data at ack.
        if (flush_i) flushed_d = 1'b1;
        if (bus.bus_ack) begin
          req_d = 1'b0;
          if (flushed_q || flush_i) begin
            load_data_d = '0;
            state_d     = MEM_IDLE;
          end else begin
            load_data_d = lane_ldata;
            state_d     = MEM_DONE;
          end
        end
      end
      MEM_DONE: begin
        if (flush_i) begin
          load_data_d = '0;
          state_d     = MEM_IDLE;
        end else if (stall_i[4] == NO_STOP) begin
          state_d = MEM_IDLE;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  // State and output registers; reset drops the request immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= MEM_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      sel_q       <= 4'b0000;
      wdata_q     <= '0;
      op_q        <= EXE_NOP_OP;
      a_q         <= 2'b00;
      flushed_q   <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      sel_q       <= sel_d;
      wdata_q     <= wdata_d;
      op_q        <= op_d;
      a_q         <= a_d;
      flushed_q   <= flushed_d;
      load_data_q <= load_data_d;
    end
  end

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_sel   = sel_q;
  assign bus.bus_wdata = wdata_q;
  assign load_data_o   = load_data_q;

endmodule

// File: tb/tb_risc32_mem_bus_if.sv
// Directed bench for the MEM-stage bus master with a load-data scoreboard.
// Latency: checks req at cycle 1 and load data the cycle after ack.
// Backpressure: exercises ack wait states and stall[4] holds in DONE.
module tb_risc32_mem_bus_if;
  import risc32_mem_bus_if_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = 6'b0;
  logic        flush = 1'b0;
  logic [7:0]  alu_op = EXE_NOP_OP;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] reg2 = 32'h0;
  logic [31:0] load_data;
  logic        stallreq;
`ifdef RISC32_MEM_ALIGN_CHECK_EN
  logic [1:0]  addr_err;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] sb[$];

  risc32_dbus_if bus_if ();

  risc32_mem_bus_if dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall),
    .flush_i     (flush),
    .alu_op_i    (alu_op),
    .mem_addr_i  (mem_addr),
    .reg2_i      (reg2),
    .bus         (bus_if),
    .load_data_o (load_data),
    .stallreq_o  (stallreq)
`ifdef RISC32_MEM_ALIGN_CHECK_EN
    ,
    .addr_err_o  (addr_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    logic [31:0] e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s observed=load with empty scoreboard expected=queued entry", tag);
    end else begin
      e = sb.pop_front();
      chk(tag, load_data, e);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [7:0] op, input logic [1:0] a,
                                             input logic [31:0] rd);
    logic [31:0] b, h;
    b = rd >> (8 * (3 - int'(a)));
    h = rd >> (a[1] ? 0 : 16);
    case (op)
      EXE_LB_OP:  return {{24{b[7]}}, b[7:0]};
      EXE_LBU_OP: return {24'h0, b[7:0]};
      EXE_LH_OP:  return {{16{h[15]}}, h[15:0]};
      EXE_LHU_OP: return {16'h0, h[15:0]};
      EXE_LW_OP:  return rd;
      default:    return 32'h0;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full transaction, entered and left at a negedge with the FSM in IDLE.
  task automatic txn(input string tag, input logic [7:0] op, input logic [31:0] addr,
                     input logic [31:0] r2, input logic [31:0] rdata, input int waits,
                     input logic [3:0] xsel, input logic [31:0] xwdata);
    logic st;
    st = (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    alu_op = op; mem_addr = addr; reg2 = r2;
    sb.push_back(st ? 32'h0 : model_load(op, addr[1:0], rdata));
    #1;
    chk({tag, "/c0_stallreq"}, stallreq, 1);
    chk({tag, "/c0_req"}, bus_if.bus_req, 0);
    cyc();
    chk({tag, "/req"}, bus_if.bus_req, 1);
    chk({tag, "/addr"}, bus_if.bus_addr, addr & 32'hFFFF_FFFC);
    chk({tag, "/sel"}, bus_if.bus_sel, xsel);
    chk({tag, "/we"}, bus_if.bus_we, st);
    if (st) chk({tag, "/wdata"}, bus_if.bus_wdata, xwdata);
    repeat (waits) begin
      cyc();
      chk({tag, "/wait_req"}, bus_if.bus_req, 1);
      chk({tag, "/wait_sel"}, bus_if.bus_sel, xsel);
    end
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = rdata;
    #1;
    chk({tag, "/ack_stallreq"}, stallreq, 1);
    cyc();
    bus_if.bus_ack = 1'b0;
    #1;
    chk({tag, "/done_stallreq"}, stallreq, 0);
    chk({tag, "/done_req"}, bus_if.bus_req, 0);
    sb_check({tag, "/load_data"});
    alu_op = EXE_NOP_OP;
    cyc();
  endtask

  initial begin
    bus_if.bus_ack = 1'b0;
    bus_if.bus_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst/req", bus_if.bus_req, 0);
    chk("rst/we", bus_if.bus_we, 0);
    chk("rst/addr", bus_if.bus_addr, 0);
    chk("rst/sel", bus_if.bus_sel, 0);
    chk("rst/wdata", bus_if.bus_wdata, 0);
    chk("rst/load_data", load_data, 0);
    chk("rst/stallreq", stallreq, 0);
    rst = 1'b0;
    cyc();

    txn("lw", EXE_LW_OP, 32'h100, 32'h0, 32'hDEADBEEF, 0, 4'b1111, 32'h0);

    // Flush while REQ: bus cycle completes, data dropped, straight back to IDLE.
    alu_op = EXE_LW_OP; mem_addr = 32'h300;
    sb.push_back(32'h0);
    cyc();
    chk("flush/req_c1", bus_if.bus_req, 1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    #1;
    chk("flush/req_c2", bus_if.bus_req, 1);
    chk("flush/stallreq_c2", stallreq, 1);
    @(negedge clk);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h55667788;
    #1;
    chk("flush/req_ack", bus_if.bus_req, 1);
    cyc();
    bus_if.bus_ack = 1'b0;
    #1;
    chk("flush/req_after", bus_if.bus_req, 0);
    sb_check("flush/load_data");
    // Op still present: stallreq=1 only if the FSM is already back in IDLE.
    txn("lw_after_flush", EXE_LW_OP, 32'h300, 32'h0, 32'h55667788, 1, 4'b1111, 32'h0);

    txn("lb", EXE_LB_OP, 32'h103, 32'h0, 32'h000000F0, 0, 4'b0001, 32'h0);
    txn("lbu", EXE_LBU_OP, 32'h103, 32'h0, 32'h000000F0, 0, 4'b0001, 32'h0);
    txn("sh", EXE_SH_OP, 32'h202, 32'h1234ABCD, 32'h0, 3, 4'b0011, 32'hABCDABCD);
    txn("lh", EXE_LH_OP, 32'h100, 32'h0, 32'h80017777, 0, 4'b1100, 32'h0);
    txn("lhu", EXE_LHU_OP, 32'h102, 32'h0, 32'h12348765, 2, 4'b0011, 32'h0);
    txn("sb", EXE_SB_OP, 32'h101, 32'h000000AB, 32'h0, 1, 4'b0100, 32'hABABABAB);
    txn("sw", EXE_SW_OP, 32'h10C, 32'hCAFEF00D, 32'h0, 0, 4'b1111, 32'hCAFEF00D);
`ifdef RISC32_MEM_ALIGN_CHECK_EN
    alu_op = EXE_LW_OP; mem_addr = 32'h101;
    #1;
    chk("mis/stallreq", stallreq, 0);
    cyc();
    chk("mis/req", bus_if.bus_req, 0);
    chk("mis/err", addr_err, 2'b10);
    alu_op = EXE_NOP_OP;
    cyc();
    chk("mis/err_clr", addr_err, 2'b00);
`else
    txn("lw_mis", EXE_LW_OP, 32'h106, 32'h0, 32'h01020304, 0, 4'b1111, 32'h0);
`endif

    // Ack while IDLE is ignored.
    txn("lw_pre_idle_ack", EXE_LW_OP, 32'h108, 32'h0, 32'h0BADF00D, 0, 4'b1111, 32'h0);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hFFFF_FFFF;
    #1;
    chk("idle_ack/req", bus_if.bus_req, 0);
    chk("idle_ack/stallreq", stallreq, 0);
    cyc();
    bus_if.bus_ack = 1'b0;
    chk("idle_ack/load_data", load_data, 32'h0BADF00D);

    // DONE held by stall[4] for two cycles.
    alu_op = EXE_LW_OP; mem_addr = 32'h104;
    sb.push_back(model_load(EXE_LW_OP, 2'b00, 32'h13572468));
    cyc();
    chk("hold/req", bus_if.bus_req, 1);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h13572468; stall = 6'b010000;
    cyc();
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
    #1;
    chk("hold/stallreq1", stallreq, 0);
    sb_check("hold/load_data1");
    cyc();
    chk("hold/stallreq2", stallreq, 0);
    chk("hold/load_data2", load_data, 32'h13572468);
    stall = 6'b000000;
    cyc();
    stall = 6'b001000;
    #1;
    chk("hold/idle_stallreq", stallreq, 1);
    cyc();
    chk("hold/stall3_no_req", bus_if.bus_req, 0);
    chk("hold/load_data3", load_data, 32'h13572468);
    stall = 6'b000000;
    cyc();
    chk("hold/relaunch_req", bus_if.bus_req, 1);

    // Asynchronous reset mid-transaction.
    rst = 1'b1;
    #1;
    chk("arst/req", bus_if.bus_req, 0);
    chk("arst/load_data", load_data, 0);
    alu_op = EXE_NOP_OP;
    cyc();
    rst = 1'b0;
    cyc();
    chk("arst/idle_req", bus_if.bus_req, 0);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
